// File: rtl/univ_shift_seq.sv
// Universal shift register with a small two-state sequencer.
// A start request runs a shift-class mode for `count` consecutive edges.
module univ_shift_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       mode,
    input  logic             lin,
    input  logic             rin,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] dout,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_dout, w_dout_nxt;
    logic             r_sout, w_sout_nxt;
    logic             r_done, w_done_nxt;
    logic [CNT_W-1:0] r_rem, w_rem_nxt;
    logic [2:0]       r_mode, w_mode_nxt;

    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_op_dout;
    logic             w_op_sout;

    function automatic logic is_shift(input logic [2:0] m);
        return (m == 3'd1) || (m == 3'd2) || (m == 3'd4) || (m == 3'd5) || (m == 3'd6);
    endfunction

    // While running, the captured mode drives the datapath; live inputs are ignored.
    always_comb begin
        w_op      = (r_state == S_RUN) ? r_mode : mode;
        w_op_dout = r_dout;
        w_op_sout = r_sout;
        case (w_op)
            3'd1: begin w_op_dout = {rin, r_dout[WIDTH-1:1]};         w_op_sout = r_dout[0];       end
            3'd2: begin w_op_dout = {r_dout[WIDTH-2:0], lin};         w_op_sout = r_dout[WIDTH-1]; end
            3'd3: w_op_dout = din;
            3'd4: begin w_op_dout = {r_dout[0], r_dout[WIDTH-1:1]};   w_op_sout = r_dout[0];       end
            3'd5: begin w_op_dout = {r_dout[WIDTH-2:0], r_dout[WIDTH-1]}; w_op_sout = r_dout[WIDTH-1]; end
            3'd6: begin w_op_dout = {r_dout[WIDTH-1], r_dout[WIDTH-1:1]}; w_op_sout = r_dout[0];    end
            3'd7: w_op_dout = '0;
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dout_nxt  = r_dout;
        w_sout_nxt  = r_sout;
        w_rem_nxt   = r_rem;
        w_mode_nxt  = r_mode;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && is_shift(mode)) begin
                    if (count != '0) begin
                        w_dout_nxt = w_op_dout;
                        w_sout_nxt = w_op_sout;
                        w_mode_nxt = mode;
                        if (count == CNT_W'(1)) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_RUN;
                            w_rem_nxt   = count - CNT_W'(1);
                        end
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end else begin
                    w_dout_nxt = w_op_dout;
                    w_sout_nxt = w_op_sout;
                end
            end
            S_RUN: begin
                w_dout_nxt = w_op_dout;
                w_sout_nxt = w_op_sout;
                if (r_rem == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_rem_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_rem_nxt = r_rem - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_dout  <= '0;
            r_sout  <= 1'b0;
            r_done  <= 1'b0;
            r_rem   <= '0;
            r_mode  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dout  <= w_dout_nxt;
            r_sout  <= w_sout_nxt;
            r_done  <= w_done_nxt;
            r_rem   <= w_rem_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    assign dout = r_dout;
    assign sout = r_sout;
    assign busy = (r_state == S_RUN);
    assign done = r_done;

endmodule

// File: tb/tb_univ_shift_seq.sv
// Bench for univ_shift_seq: directed literal checks plus randomized traffic
// compared every cycle against an arithmetic model of the register.
module tb_univ_shift_seq;
    localparam int W   = 8;
    localparam int CW  = 4;
    localparam int MSK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  din = '0;
    logic [2:0]    mode = '0;
    logic          lin = 1'b0, rin = 1'b0, start = 1'b0;
    logic [CW-1:0] count = '0;
    logic [W-1:0]  dout;
    logic          sout, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // model state: register value, last bit out, steps still owed, run mode
    int m_d = 0, m_s = 0, m_left = 0, m_mode = 0, m_done = 0;

    univ_shift_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .din(din), .mode(mode), .lin(lin), .rin(rin),
        .start(start), .count(count), .dout(dout), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_is_shift(input int md);
        return md == 1 || md == 2 || md == 4 || md == 5 || md == 6;
    endfunction

    task automatic m_apply(input int md);
        int msb, lsb;
        msb = (m_d >> (W-1)) & 1;
        lsb = m_d & 1;
        case (md)
            1: begin m_s = lsb; m_d = (m_d >> 1) | (int'(rin) << (W-1)); end
            2: begin m_s = msb; m_d = ((m_d << 1) & MSK) | int'(lin); end
            3: m_d = int'(din);
            4: begin m_s = lsb; m_d = (m_d >> 1) | (lsb << (W-1)); end
            5: begin m_s = msb; m_d = ((m_d << 1) & MSK) | msb; end
            6: begin m_s = lsb; m_d = (m_d >> 1) | (msb << (W-1)); end
            7: m_d = 0;
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_d = 0; m_s = 0; m_left = 0; m_mode = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_apply(m_mode);
                m_left--;
                if (m_left == 0) m_done = 1;
            end else if (start && m_is_shift(int'(mode))) begin
                if (count == 0) m_done = 1;
                else begin
                    m_mode = int'(mode);
                    m_apply(m_mode);
                    m_left = int'(count) - 1;
                    if (m_left == 0) m_done = 1;
                end
            end else begin
                m_apply(int'(mode));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_dout", dout, m_d);
            chk("model_sout", sout, m_s);
            chk("model_busy", busy, m_left > 0);
            chk("model_done", done, m_done);
        end
    end

    task automatic drive(input int md, input int d, input bit st, input int cnt, input bit l, input bit r);
        mode = 3'(md); din = W'(d); start = st; count = CW'(cnt); lin = l; rin = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("reset_dout", dout, 0);
        chk("reset_sout", sout, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        #10 reset = 1'b1;
        chk_en = 1'b1;

        // right-shift run of 3 with rin=1
        drive(3, 'hA5, 0, 0, 0, 0); tick();
        chk("r030_load", dout, 'hA5);
        drive(1, 0, 1, 3, 0, 1); tick();
        chk("r030_s1", dout, 'hD2); chk("r030_busy1", busy, 1); chk("r030_done1", done, 0);
        drive(0, 0, 0, 0, 0, 1); tick();
        chk("r030_s2", dout, 'hE9); chk("r030_busy2", busy, 1); chk("r030_done2", done, 0);
        tick();
        chk("r030_s3", dout, 'hF4); chk("r030_busy3", busy, 0); chk("r030_done3", done, 1);
        tick();
        chk("r030_done_clr", done, 0);

        // rotate-left run of 9 wraps to a single rotate
        drive(3, 'h81, 0, 0, 0, 0); tick();
        drive(5, 0, 1, 9, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            chk("r031_done", done, i == 9);
            chk("r031_busy", busy, i < 9);
            if (i < 9) tick();
        end
        chk("r031_final", dout, 'h03);

        // arithmetic right single steps
        drive(3, 'h80, 0, 0, 0, 0); tick();
        drive(6, 0, 0, 0, 0, 0); tick();
        chk("r032_a", dout, 'hC0); chk("r032_a_sout", sout, 0);
        drive(3, 'h41, 0, 0, 0, 0); tick();
        drive(6, 0, 0, 0, 0, 0); tick();
        chk("r032_b", dout, 'h20); chk("r032_b_sout", sout, 1);

        // count=0 start
        drive(3, 'h3C, 0, 0, 0, 0); tick();
        drive(2, 0, 1, 0, 1, 1); tick();
        chk("r033_dout", dout, 'h3C); chk("r033_busy", busy, 0); chk("r033_done", done, 1);
        drive(0, 0, 0, 0, 0, 0); tick();
        chk("r033_done_clr", done, 0); chk("r033_hold", dout, 'h3C);

        // start with non-shift mode acts as single step
        drive(3, 'h5A, 1, 4, 0, 0); tick();
        chk("r024_dout", dout, 'h5A); chk("r024_busy", busy, 0); chk("r024_done", done, 0);

        // inputs ignored while busy
        drive(3, 'h96, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 5, 0, 0); tick();
        chk("r034_s1", dout, 'h4B);
        drive(3, 'hFF, 1, 7, 0, 0);
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk("r034_done", done, i == 5);
        end
        chk("r034_final", dout, 'h04);
        drive(0, 0, 0, 0, 0, 0); tick();

        // async reset mid-run
        drive(3, 'hFF, 0, 0, 0, 0); tick();
        drive(2, 0, 1, 8, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        chk("r035_busy_pre", busy, 1);
        #3 reset = 1'b0;
        #1;
        chk("r035_dout", dout, 0); chk("r035_busy", busy, 0); chk("r035_done", done, 0);
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("r035_no_done", done, 0);
        end
        drive(3, 'h6E, 0, 0, 0, 0); tick();
        chk("r029_load", dout, 'h6E);

        // randomized traffic, model compare runs every cycle
        repeat (500) begin
            drive($urandom_range(0, 7), $urandom_range(0, MSK), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1));
            if ($urandom_range(0, 80) == 0) begin
                reset = 1'b0;
                #2 reset = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
